// File: rtl/des_pkg.sv
// rtl/des_pkg.sv - DES IP / IP^-1 index tables, mode encodings and block width.
package des_pkg;

    localparam int BLOCK_W = 64;

    typedef enum logic {
        DES_MODE_IP    = 1'b0,
        DES_MODE_IPINV = 1'b1
    } des_mode_e;

    // Entry i-1 names the DES input bit that lands on DES output bit i.
    localparam int unsigned IP_TABLE [BLOCK_W] = '{
        58, 50, 42, 34, 26, 18, 10,  2,
        60, 52, 44, 36, 28, 20, 12,  4,
        62, 54, 46, 38, 30, 22, 14,  6,
        64, 56, 48, 40, 32, 24, 16,  8,
        57, 49, 41, 33, 25, 17,  9,  1,
        59, 51, 43, 35, 27, 19, 11,  3,
        61, 53, 45, 37, 29, 21, 13,  5,
        63, 55, 47, 39, 31, 23, 15,  7
    };

    localparam int unsigned IPINV_TABLE [BLOCK_W] = '{
        40,  8, 48, 16, 56, 24, 64, 32,
        39,  7, 47, 15, 55, 23, 63, 31,
        38,  6, 46, 14, 54, 22, 62, 30,
        37,  5, 45, 13, 53, 21, 61, 29,
        36,  4, 44, 12, 52, 20, 60, 28,
        35,  3, 43, 11, 51, 19, 59, 27,
        34,  2, 42, 10, 50, 18, 58, 26,
        33,  1, 41,  9, 49, 17, 57, 25
    };

endpackage

// File: rtl/des_perm_core.sv
// rtl/des_perm_core.sv - combinational DES IP / IP^-1; DES_PERM_SWAP_EN adds the L/R swap before IP^-1.
module des_perm_core
    import des_pkg::*;
(
    input  logic [BLOCK_W:1] data,
    input  logic             mode,
    output logic [BLOCK_W:1] result
);

    logic [BLOCK_W:1] src;

`ifdef DES_PERM_SWAP_EN
    assign src = (mode == DES_MODE_IPINV) ? {data[32:1], data[64:33]} : data;
`else
    assign src = data;
`endif

    // DES bit n lives at vector index 65-n, so the leftmost hex digit holds DES bits 1..4.
    for (genvar i = 1; i <= BLOCK_W; i++) begin : g_bit
        assign result[BLOCK_W + 1 - i] = (mode == DES_MODE_IPINV)
                                       ? src[BLOCK_W + 1 - IPINV_TABLE[i - 1]]
                                       : src[BLOCK_W + 1 - IP_TABLE[i - 1]];
    end

endmodule

// File: rtl/des_perm_pipe.sv
// rtl/des_perm_pipe.sv - valid/ready pipelined DES IP / IP^-1 with sideband tag (DES_PERM_SWAP_EN in core).
module des_perm_pipe
    import des_pkg::*;
#(
    parameter int PIPE_STAGES = 2,
    parameter int TAG_W       = 4
)
(
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BLOCK_W:1]   in_data,
    input  logic               in_mode,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BLOCK_W:1]   out_data,
    output logic [TAG_W-1:0]   out_tag,
    output logic               busy
);

    logic [BLOCK_W:1]       perm_data;
    logic [PIPE_STAGES-1:0] stg_valid;
    logic [PIPE_STAGES-1:0] stg_load;
    logic [BLOCK_W:1]       stg_data [PIPE_STAGES];
    logic [TAG_W-1:0]       stg_tag  [PIPE_STAGES];

    des_perm_core u_core (
        .data   (in_data),
        .mode   (in_mode),
        .result (perm_data)
    );

    // A stage may load when empty or when its occupant leaves this cycle.
    always_comb begin
        stg_load = '0;
        stg_load[PIPE_STAGES-1] = !stg_valid[PIPE_STAGES-1] || out_ready;
        for (int k = PIPE_STAGES - 2; k >= 0; k--) begin
            stg_load[k] = !stg_valid[k] || stg_load[k+1];
        end
    end

    assign in_ready = !rst && stg_load[0];

    // Data/tag only move with a valid block so the outputs keep the last result across bubbles.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < PIPE_STAGES; k++) begin
                stg_valid[k] <= 1'b0;
                stg_data[k]  <= '0;
                stg_tag[k]   <= '0;
            end
        end else begin
            if (stg_load[0]) begin
                stg_valid[0] <= in_valid;
                if (in_valid) begin
                    stg_data[0] <= perm_data;
                    stg_tag[0]  <= in_tag;
                end
            end
            for (int k = 1; k < PIPE_STAGES; k++) begin
                if (stg_load[k]) begin
                    stg_valid[k] <= stg_valid[k-1];
                    if (stg_valid[k-1]) begin
                        stg_data[k] <= stg_data[k-1];
                        stg_tag[k]  <= stg_tag[k-1];
                    end
                end
            end
        end
    end

    assign out_valid = stg_valid[PIPE_STAGES-1];
    assign out_data  = stg_data[PIPE_STAGES-1];
    assign out_tag   = stg_tag[PIPE_STAGES-1];
    assign busy      = |stg_valid;

endmodule

// File: tb/tb_des_perm_pipe.sv
// tb/tb_des_perm_pipe.sv - bench for des_perm_pipe at PIPE_STAGES 2/1/4 and TAG_W 4/4/1.
module tb_des_perm_pipe;

    localparam int NDUT = 3;

    localparam int TB_IP [64] = '{
        58, 50, 42, 34, 26, 18, 10,  2,
        60, 52, 44, 36, 28, 20, 12,  4,
        62, 54, 46, 38, 30, 22, 14,  6,
        64, 56, 48, 40, 32, 24, 16,  8,
        57, 49, 41, 33, 25, 17,  9,  1,
        59, 51, 43, 35, 27, 19, 11,  3,
        61, 53, 45, 37, 29, 21, 13,  5,
        63, 55, 47, 39, 31, 23, 15,  7
    };

    typedef struct {
        logic        mode;
        logic [63:0] data;
        logic [3:0]  tag;
        logic [63:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst;

    logic        in_valid  [NDUT];
    logic [63:0] in_data   [NDUT];
    logic        in_mode   [NDUT];
    logic [3:0]  in_tag    [NDUT];
    logic        out_ready [NDUT];

    logic        ir_a [NDUT];
    logic        ov_a [NDUT];
    logic [63:0] od_a [NDUT];
    logic [3:0]  ot_a [NDUT];
    logic        bz_a [NDUT];

    logic        ir0, ir1, ir2, ov0, ov1, ov2, bz0, bz1, bz2;
    logic [63:0] od0, od1, od2;
    logic [3:0]  ot0, ot1;
    logic [0:0]  ot2;

    int checks = 0;
    int passes = 0;
    vec_t vecs [8];

    always #5 clk = ~clk;

    des_perm_pipe #(.PIPE_STAGES(2), .TAG_W(4)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(ir0), .in_data(in_data[0]),
        .in_mode(in_mode[0]), .in_tag(in_tag[0]), .out_valid(ov0), .out_ready(out_ready[0]),
        .out_data(od0), .out_tag(ot0), .busy(bz0));

    des_perm_pipe #(.PIPE_STAGES(1), .TAG_W(4)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(ir1), .in_data(in_data[1]),
        .in_mode(in_mode[1]), .in_tag(in_tag[1]), .out_valid(ov1), .out_ready(out_ready[1]),
        .out_data(od1), .out_tag(ot1), .busy(bz1));

    des_perm_pipe #(.PIPE_STAGES(4), .TAG_W(1)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(ir2), .in_data(in_data[2]),
        .in_mode(in_mode[2]), .in_tag(in_tag[2][0:0]), .out_valid(ov2), .out_ready(out_ready[2]),
        .out_data(od2), .out_tag(ot2), .busy(bz2));

    always_comb begin
        ir_a[0] = ir0; ir_a[1] = ir1; ir_a[2] = ir2;
        ov_a[0] = ov0; ov_a[1] = ov1; ov_a[2] = ov2;
        od_a[0] = od0; od_a[1] = od1; od_a[2] = od2;
        ot_a[0] = ot0; ot_a[1] = ot1; ot_a[2] = {3'b000, ot2};
        bz_a[0] = bz0; bz_a[1] = bz1; bz_a[2] = bz2;
    end

    function automatic int nst(input int d);
        return (d == 0) ? 2 : (d == 1) ? 1 : 4;
    endfunction

    function automatic logic [3:0] tmask(input int d);
        return (d == 2) ? 4'h1 : 4'hF;
    endfunction

    // IP straight from the table; IP^-1 derived by inverting it rather than from a second table.
    function automatic logic [63:0] ref_perm(input logic [63:0] x, input logic m);
        logic [63:0] s;
        logic [63:0] r;
        s = x;
`ifdef DES_PERM_SWAP_EN
        if (m) s = {x[31:0], x[63:32]};
`endif
        r = '0;
        for (int i = 1; i <= 64; i++) begin
            if (m) r[64 - TB_IP[i-1]] = s[64 - i];
            else   r[64 - i] = s[64 - TB_IP[i-1]];
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic apply_vec(input int d, input vec_t v);
        int lat;
        @(negedge clk);
        in_valid[d] = 1'b1; in_data[d] = v.data; in_mode[d] = v.mode; in_tag[d] = v.tag;
        out_ready[d] = 1'b1;
        #1;
        check("vec in_ready", 64'(ir_a[d]), 64'd1);
        @(posedge clk); #1;
        in_valid[d] = 1'b0;
        lat = 1;
        while (!ov_a[d] && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("vec latency", 64'(lat), 64'(nst(d)));
        check("vec out_data", od_a[d], v.exp);
        check("vec out_tag", 64'(ot_a[d]), 64'(v.tag & tmask(d)));
        @(posedge clk); #1;
        check("vec out_valid drop", 64'(ov_a[d]), 64'd0);
        check("vec out_data held", od_a[d], v.exp);
    endtask

    task automatic run_stream(input int d, input bit full_rate);
        logic [63:0] exp_q [$];
        logic [3:0]  tag_q [$];
        logic [63:0] blk [32];
        logic [63:0] sd;
        logic [3:0]  st;
        logic [63:0] e;
        logic [3:0]  et;
        int sent = 0;
        int got = 0;
        int cyc = 0;
        bit stall = 0;
        bit acc, ocmp;
        for (int i = 0; i < 32; i++) blk[i] = {$urandom, $urandom};
        while (got < 32 && cyc < 3000) begin
            @(negedge clk);
            if (stall) begin
                check("stall out_valid", 64'(ov_a[d]), 64'd1);
                check("stall out_data", od_a[d], sd);
                check("stall out_tag", 64'(ot_a[d]), 64'(st));
            end
            in_valid[d]  = (sent < 32);
            in_data[d]   = blk[sent % 32];
            in_mode[d]   = sent[0];
            in_tag[d]    = sent[3:0];
            out_ready[d] = full_rate ? 1'b1 : 1'($urandom_range(0, 1));
            #1;
            acc  = in_valid[d] && ir_a[d];
            ocmp = ov_a[d] && out_ready[d];
            if (full_rate && sent < 32) check("full rate in_ready", 64'(ir_a[d]), 64'd1);
            stall = ov_a[d] && !out_ready[d];
            sd = od_a[d];
            st = ot_a[d];
            @(posedge clk);
            cyc++;
            if (ocmp) begin
                if (exp_q.size() == 0) begin
                    check("stream unexpected output", od_a[d], 64'd0 - 64'd1);
                end else begin
                    e  = exp_q.pop_front();
                    et = tag_q.pop_front();
                    check("stream out_data", sd, e);
                    check("stream out_tag", 64'(st), 64'(et));
                end
                got++;
            end
            if (acc) begin
                exp_q.push_back(ref_perm(blk[sent], sent[0]));
                tag_q.push_back(sent[3:0] & tmask(d));
                sent++;
            end
        end
        @(negedge clk);
        in_valid[d] = 1'b0;
        out_ready[d] = 1'b1;
        check("stream all delivered", 64'(got), 64'd32);
        check("stream no leftovers", 64'(exp_q.size()), 64'd0);
        if (full_rate) check("stream full rate cycles", 64'(cyc), 64'(32 + nst(d)));
    endtask

    task automatic fill_and_reset(input int d);
        int acc_n = 0;
        bit seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            in_valid[d] = 1'b1; in_data[d] = {32'hDEAD0000, 32'(i)}; in_mode[d] = 1'b0;
            in_tag[d] = 4'(i); out_ready[d] = 1'b0;
            #1;
            if (ir_a[d]) acc_n++;
            @(posedge clk);
        end
        #1;
        check("fill accepts", 64'(acc_n), 64'(nst(d)));
        check("fill in_ready low", 64'(ir_a[d]), 64'd0);
        check("fill busy", 64'(bz_a[d]), 64'd1);
        check("fill out_valid", 64'(ov_a[d]), 64'd1);
        @(negedge clk);
        in_valid[d] = 1'b0;
        rst = 1'b1;
        #1;
        check("rst in_ready low", 64'(ir_a[d]), 64'd0);
        @(posedge clk); #1;
        check("rst out_valid", 64'(ov_a[d]), 64'd0);
        check("rst busy", 64'(bz_a[d]), 64'd0);
        check("rst out_data", od_a[d], 64'd0);
        check("rst out_tag", 64'(ot_a[d]), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        out_ready[d] = 1'b1;
        #1;
        check("post rst in_ready", 64'(ir_a[d]), 64'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ov_a[d] || bz_a[d]) seen = 1;
        end
        check("no stale block", 64'(seen), 64'd0);
    endtask

    initial begin
        vecs[0] = '{1'b0, 64'h0123456789ABCDEF, 4'h3, 64'hCC00CCFFF0AAF0AA};
`ifdef DES_PERM_SWAP_EN
        vecs[1] = '{1'b1, 64'hF0AAF0AACC00CCFF, 4'h5, 64'h0123456789ABCDEF};
        vecs[2] = '{1'b1, 64'h434232340A4CD995, 4'hA, 64'h85E813540F0AB405};
        vecs[5] = '{1'b1, 64'h0100000000000000, 4'hF, 64'h8000000000000000};
`else
        vecs[1] = '{1'b1, 64'hCC00CCFFF0AAF0AA, 4'h5, 64'h0123456789ABCDEF};
        vecs[2] = '{1'b1, 64'h0A4CD99543423234, 4'hA, 64'h85E813540F0AB405};
        vecs[5] = '{1'b1, 64'h0000000001000000, 4'hF, 64'h8000000000000000};
`endif
        vecs[3] = '{1'b0, 64'h8000000000000000, 4'h1, 64'h0000000001000000};
        vecs[4] = '{1'b0, 64'h0000000000000001, 4'h2, 64'h0000008000000000};
        vecs[6] = '{1'b0, 64'hFFFFFFFFFFFFFFFF, 4'h0, 64'hFFFFFFFFFFFFFFFF};
        vecs[7] = '{1'b1, 64'h0000000000000000, 4'h7, 64'h0000000000000000};

        rst = 1'b1;
        for (int d = 0; d < NDUT; d++) begin
            in_valid[d] = 1'b0; in_data[d] = '0; in_mode[d] = 1'b0;
            in_tag[d] = '0; out_ready[d] = 1'b1;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < NDUT; d++) begin
            check("reset out_valid", 64'(ov_a[d]), 64'd0);
            check("reset busy", 64'(bz_a[d]), 64'd0);
            check("reset out_data", od_a[d], 64'd0);
            check("reset out_tag", 64'(ot_a[d]), 64'd0);
            check("reset in_ready", 64'(ir_a[d]), 64'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        for (int d = 0; d < NDUT; d++) check("first cycle in_ready", 64'(ir_a[d]), 64'd1);

        for (int d = 0; d < NDUT; d++)
            for (int i = 0; i < 8; i++) apply_vec(d, vecs[i]);

        for (int d = 0; d < NDUT; d++) begin
            run_stream(d, 1'b0);
            run_stream(d, 1'b1);
        end

        for (int d = 0; d < NDUT; d++) fill_and_reset(d);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
